// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, forwarding mux select codes and the single-source hazard test.
package hazard_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Operand select codes driven on fwd_a / fwd_b
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
    localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM result
    localparam logic [1:0] FWD_WB  = 2'b10;  // WB Din

    // A source conflicts with a writer only when the source is really read,
    // the writer really writes, the numbers match and the register is not $0.
    function automatic logic src_hazard(
        input logic       used,
        input logic [4:0] src,
        input logic       regwrite,
        input logic [4:0] dst
    );
        return used && regwrite && (src == dst) && (src != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: ID source registers,
// per-stage writer information and the stall/flush/forward controls.
// These are plain level signals sampled every cycle; there is no
// valid/ready handshake, every field is meaningful on every cycle.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [4:0]  id_r1;
    logic [4:0]  id_r2;
    logic        id_r1_used;
    logic        id_r2_used;
    logic [4:0]  ex_wreg;
    logic [4:0]  mem_wreg;
    logic [4:0]  wb_wreg;
    logic        ex_regwrite;
    logic        mem_regwrite;
    logic        wb_regwrite;
    logic        ex_memtoreg;
    logic        ex_redirect;
    logic        ex_halt;

    logic        pc_enable;
    logic        if_id_enable;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        halted;
    logic [31:0] stall_count;
    logic [31:0] flush_count;
    state_t      dbg_state;

    // Pipeline side: supplies instruction information, consumes controls
    modport master (
        output id_r1, id_r2, id_r1_used, id_r2_used,
        output ex_wreg, mem_wreg, wb_wreg,
        output ex_regwrite, mem_regwrite, wb_regwrite,
        output ex_memtoreg, ex_redirect, ex_halt,
        input  pc_enable, if_id_enable, if_id_flush, id_ex_flush,
        input  fwd_a, fwd_b, halted, stall_count, flush_count, dbg_state
    );

    // Hazard controller side
    modport slave (
        input  id_r1, id_r2, id_r1_used, id_r2_used,
        input  ex_wreg, mem_wreg, wb_wreg,
        input  ex_regwrite, mem_regwrite, wb_regwrite,
        input  ex_memtoreg, ex_redirect, ex_halt,
        output pc_enable, if_id_enable, if_id_flush, id_ex_flush,
        output fwd_a, fwd_b, halted, stall_count, flush_count, dbg_state
    );

endinterface

// File: rtl/hazard_ctrl_go_sync.sv
// Go button conditioner: two-flop synchronizer followed by a rising-edge
// detector. pulse is high for exactly one cycle per synchronized rise, so a
// button held high produces a single pulse.
module go_sync (
    input  logic clk,
    input  logic clr,
    input  logic go,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronize the asynchronous button and remember last synchronized level
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= go;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use / data-hazard stalls,
// redirect flushes, halt-until-Go, stall/flush event counters.
// Build option HAZARD_FORWARD_EN: when defined, operands are forwarded from
// EX/MEM (preferred) or WB and only load-use stalls; when undefined, the
// forward selects are tied to the register file and any hazard against
// EX, MEM or WB stalls.
// A halting syscall in EX takes precedence over everything in its cycle:
// the front end is frozen, nothing is flushed and no counter moves.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    input  logic          Go,
    hazard_ctrl_if.slave  bus
);

    state_t      state;
    logic        halted_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        go_pulse;

    logic        ex_haz;
    logic        mem_haz_a;
    logic        mem_haz_b;
    logic        wb_haz_a;
    logic        wb_haz_b;
    logic        load_stall;
    logic        stall;

    logic        pc_en_c;
    logic        if_id_en_c;
    logic        if_id_flush_c;
    logic        id_ex_flush_c;
    logic        stall_inc;
    logic        flush_inc;

    go_sync u_go_sync (
        .clk   (clk),
        .clr   (clr),
        .go    (Go),
        .pulse (go_pulse)
    );

    // Per-stage hazard detection against both ID sources
    always_comb begin
        ex_haz    = src_hazard(bus.id_r1_used, bus.id_r1, bus.ex_regwrite, bus.ex_wreg)
                  | src_hazard(bus.id_r2_used, bus.id_r2, bus.ex_regwrite, bus.ex_wreg);
        mem_haz_a = src_hazard(bus.id_r1_used, bus.id_r1, bus.mem_regwrite, bus.mem_wreg);
        mem_haz_b = src_hazard(bus.id_r2_used, bus.id_r2, bus.mem_regwrite, bus.mem_wreg);
        wb_haz_a  = src_hazard(bus.id_r1_used, bus.id_r1, bus.wb_regwrite, bus.wb_wreg);
        wb_haz_b  = src_hazard(bus.id_r2_used, bus.id_r2, bus.wb_regwrite, bus.wb_wreg);
        load_stall = bus.ex_memtoreg & ex_haz;
    end

`ifdef HAZARD_FORWARD_EN
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;

    // Forward select: the younger EX/MEM result wins over WB
    always_comb begin
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
        if (mem_haz_a)     fwd_a_c = FWD_MEM;
        else if (wb_haz_a) fwd_a_c = FWD_WB;
        if (mem_haz_b)     fwd_b_c = FWD_MEM;
        else if (wb_haz_b) fwd_b_c = FWD_WB;
    end

    assign stall     = load_stall;
    assign bus.fwd_a = clr ? fwd_a_c : FWD_RF;
    assign bus.fwd_b = clr ? fwd_b_c : FWD_RF;
`else
    // Without forwarding, any pending writer of a source must drain first
    assign stall     = load_stall | ex_haz | mem_haz_a | mem_haz_b | wb_haz_a | wb_haz_b;
    assign bus.fwd_a = FWD_RF;
    assign bus.fwd_b = FWD_RF;
`endif

    // Pipeline controls for this cycle: halt > redirect > stall > run
    always_comb begin
        pc_en_c       = 1'b1;
        if_id_en_c    = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (state == ST_HALT || bus.ex_halt) begin
            pc_en_c    = 1'b0;
            if_id_en_c = 1'b0;
        end else if (bus.ex_redirect) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            flush_inc     = 1'b1;
        end else if (stall) begin
            pc_en_c       = 1'b0;
            if_id_en_c    = 1'b0;
            id_ex_flush_c = 1'b1;
            stall_inc     = 1'b1;
        end
    end

    // RUN/HALT state machine with registered halted flag
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.ex_halt) begin
                        state    <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (go_pulse) begin
                        state    <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_inc && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_inc && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.pc_enable    = pc_en_c;
    assign bus.if_id_enable = if_id_en_c;
    assign bus.if_id_flush  = if_id_flush_c;
    assign bus.id_ex_flush  = id_ex_flush_c;
    assign bus.halted       = halted_q;
    assign bus.stall_count  = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;
    assign bus.dbg_state    = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl. Works for either setting of HAZARD_FORWARD_EN.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr = 1'b0;
    logic go  = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk (clk),
        .clr (clr),
        .Go  (go),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic check_en = 1'b0;
    logic preload  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_halted = 1'b0;
    logic [31:0] m_stall  = 32'd0;
    logic [31:0] m_flush  = 32'd0;
    logic        m_g1 = 1'b0, m_g2 = 1'b0, m_g3 = 1'b0;  // Go seen 1,2,3 edges ago

    function automatic logic hz(input logic used, input logic [4:0] src,
                                input logic rw, input logic [4:0] dst);
        return used && rw && (src == dst) && (src != 5'd0);
    endfunction

    function automatic logic m_stall_req();
        logic ex1, ex2, oth;
        ex1 = hz(bus.id_r1_used, bus.id_r1, bus.ex_regwrite, bus.ex_wreg);
        ex2 = hz(bus.id_r2_used, bus.id_r2, bus.ex_regwrite, bus.ex_wreg);
        oth = hz(bus.id_r1_used, bus.id_r1, bus.mem_regwrite, bus.mem_wreg)
            | hz(bus.id_r2_used, bus.id_r2, bus.mem_regwrite, bus.mem_wreg)
            | hz(bus.id_r1_used, bus.id_r1, bus.wb_regwrite, bus.wb_wreg)
            | hz(bus.id_r2_used, bus.id_r2, bus.wb_regwrite, bus.wb_wreg);
`ifdef HAZARD_FORWARD_EN
        return bus.ex_memtoreg && (ex1 || ex2);
`else
        return ex1 || ex2 || oth;
`endif
    endfunction

    function automatic logic [1:0] m_fwd(input logic used, input logic [4:0] src);
`ifdef HAZARD_FORWARD_EN
        if (hz(used, src, bus.mem_regwrite, bus.mem_wreg)) return 2'b01;
        if (hz(used, src, bus.wb_regwrite, bus.wb_wreg))   return 2'b10;
        return 2'b00;
`else
        return (used && src == 5'd31) ? 2'b00 : 2'b00;
`endif
    endfunction

    // Model state advance at each clock edge
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_halted = 1'b0;
            m_stall  = 32'd0;
            m_flush  = 32'd0;
            m_g1 = 1'b0; m_g2 = 1'b0; m_g3 = 1'b0;
        end else begin
            if (preload) begin
                m_stall = 32'hFFFF_FFFE;
            end else if (m_halted) begin
                // resume two edges after Go was first seen high
                if (m_g2 && !m_g3) m_halted = 1'b0;
            end else if (bus.ex_halt) begin
                m_halted = 1'b1;
            end else if (bus.ex_redirect) begin
                if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
            end else if (m_stall_req()) begin
                if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            end
            m_g3 = m_g2; m_g2 = m_g1; m_g1 = go;
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic e_pc, e_en, e_iff, e_ief;
        if (check_en) begin
            e_pc = 1'b1; e_en = 1'b1; e_iff = 1'b0; e_ief = 1'b0;
            if (m_halted || bus.ex_halt) begin
                e_pc = 1'b0; e_en = 1'b0;
            end else if (bus.ex_redirect) begin
                e_iff = 1'b1; e_ief = 1'b1;
            end else if (m_stall_req()) begin
                e_pc = 1'b0; e_en = 1'b0; e_ief = 1'b1;
            end
            chk("pc_enable",    32'(bus.pc_enable),    32'(e_pc));
            chk("if_id_enable", 32'(bus.if_id_enable), 32'(e_en));
            chk("if_id_flush",  32'(bus.if_id_flush),  32'(e_iff));
            chk("id_ex_flush",  32'(bus.id_ex_flush),  32'(e_ief));
            chk("fwd_a",        32'(bus.fwd_a),        32'(m_fwd(bus.id_r1_used, bus.id_r1)));
            chk("fwd_b",        32'(bus.fwd_b),        32'(m_fwd(bus.id_r2_used, bus.id_r2)));
            chk("halted",       32'(bus.halted),       32'(m_halted));
            chk("stall_count",  bus.stall_count,       m_stall);
            chk("flush_count",  bus.flush_count,       m_flush);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        bus.id_r1 = 5'd0;  bus.id_r2 = 5'd0;
        bus.id_r1_used = 1'b0; bus.id_r2_used = 1'b0;
        bus.ex_wreg = 5'd0; bus.mem_wreg = 5'd0; bus.wb_wreg = 5'd0;
        bus.ex_regwrite = 1'b0; bus.mem_regwrite = 1'b0; bus.wb_regwrite = 1'b0;
        bus.ex_memtoreg = 1'b0; bus.ex_redirect = 1'b0; bus.ex_halt = 1'b0;
    endtask

    task automatic load_use();
        idle();
        bus.ex_memtoreg = 1'b1; bus.ex_wreg = 5'd8; bus.ex_regwrite = 1'b1;
        bus.id_r1 = 5'd8; bus.id_r1_used = 1'b1;
    endtask

    task automatic rand_inputs();
        bus.id_r1 = 5'($urandom_range(0, 3));
        bus.id_r2 = 5'($urandom_range(0, 3));
        bus.id_r1_used = 1'($urandom_range(0, 1));
        bus.id_r2_used = 1'($urandom_range(0, 1));
        bus.ex_wreg  = 5'($urandom_range(0, 3));
        bus.mem_wreg = 5'($urandom_range(0, 3));
        bus.wb_wreg  = 5'($urandom_range(0, 3));
        bus.ex_regwrite  = 1'($urandom_range(0, 1));
        bus.mem_regwrite = 1'($urandom_range(0, 1));
        bus.wb_regwrite  = 1'($urandom_range(0, 1));
        bus.ex_memtoreg  = 1'($urandom_range(0, 1));
        bus.ex_redirect  = ($urandom_range(0, 7) == 0);
        bus.ex_halt      = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 4) == 0) go = ~go;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] s_save, f_save;
        int trans, resume_at;
        logic prev_h;

        idle();
        // hazard present while in reset: forward selects must still be 00
        bus.wb_wreg = 5'd5; bus.wb_regwrite = 1'b1; bus.id_r1 = 5'd5; bus.id_r1_used = 1'b1;
        #13;
        chk("rst_fwd_a",  32'(bus.fwd_a), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_stall",  bus.stall_count, 32'd0);
        chk("rst_flush",  bus.flush_count, 32'd0);
        chk("rst_state",  32'(bus.dbg_state), 32'(ST_RUN));
        step();
        idle();
        clr = 1'b1;
        step();
        check_en = 1'b1;

        // load-use: one stall cycle, counter 0 -> 1
        step(); load_use();
        at_neg();
        chk("lu_pc_enable", 32'(bus.pc_enable), 32'd0);
        chk("lu_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
        chk("lu_stall_before", bus.stall_count, 32'd0);
        step(); idle();
        at_neg();
        chk("lu_pc_after", 32'(bus.pc_enable), 32'd1);
        chk("lu_stall_after", bus.stall_count, 32'd1);

`ifdef HAZARD_FORWARD_EN
        step(); idle();
        bus.mem_wreg = 5'd9; bus.mem_regwrite = 1'b1;
        bus.wb_wreg = 5'd9;  bus.wb_regwrite = 1'b1;
        bus.id_r2 = 5'd9;    bus.id_r2_used = 1'b1;
        at_neg();
        chk("fw_fwd_b_mem", 32'(bus.fwd_b), 32'd1);
        chk("fw_no_stall", 32'(bus.pc_enable), 32'd1);
        step(); bus.id_r2 = 5'd0;
        at_neg();
        chk("fw_fwd_b_r0", 32'(bus.fwd_b), 32'd0);
`else
        step(); idle();
        bus.wb_wreg = 5'd5; bus.wb_regwrite = 1'b1; bus.id_r1 = 5'd5; bus.id_r1_used = 1'b1;
        at_neg();
        chk("nf_stall_pc", 32'(bus.pc_enable), 32'd0);
        chk("nf_stall_flush", 32'(bus.id_ex_flush), 32'd1);
        chk("nf_fwd_a", 32'(bus.fwd_a), 32'd0);
`endif

        // redirect together with a load-use stall
        step(); idle();
        at_neg();
        s_save = m_stall; f_save = m_flush;
        step(); load_use(); bus.ex_redirect = 1'b1;
        at_neg();
        chk("rd_if_id_flush", 32'(bus.if_id_flush), 32'd1);
        chk("rd_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
        chk("rd_pc_enable", 32'(bus.pc_enable), 32'd1);
        step(); idle();
        at_neg();
        chk("rd_flush_inc", bus.flush_count, f_save + 32'd1);
        chk("rd_stall_same", bus.stall_count, s_save);

        // halt, then stall-worthy inputs must not move the counters
        step(); bus.ex_halt = 1'b1;
        step(); load_use(); bus.ex_redirect = 1'b1;
        s_save = m_stall; f_save = m_flush;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            chk("h_halted", 32'(bus.halted), 32'd1);
            chk("h_stall_frozen", bus.stall_count, s_save);
            chk("h_flush_frozen", bus.flush_count, f_save);
            step();
        end
        idle(); go = 1'b1;
        // i counts clock edges after Go rose
        trans = 0; resume_at = 0; prev_h = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            bus.ex_halt = (i == 6);
            at_neg();
            if (prev_h && !bus.halted) begin
                trans++;
                resume_at = i;
            end
            prev_h = bus.halted;
        end
        chk("go_resumes_once", 32'(trans), 32'd1);
        chk("go_resume_latency", 32'(resume_at), 32'd3);
        chk("go_held_no_resume", 32'(bus.halted), 32'd1);
        step(); go = 1'b0;
        repeat (3) step();
        go = 1'b1;
        repeat (2) step();
        go = 1'b0;
        repeat (3) step();
        at_neg();
        chk("go_second_resume", 32'(bus.halted), 32'd0);

        // saturation of stall_count
        step(); idle();
        check_en = 1'b0; preload = 1'b1;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        step(); preload = 1'b0; check_en = 1'b1;
        load_use();
        repeat (3) step();
        idle();
        at_neg();
        chk("sat_stall", bus.stall_count, 32'hFFFF_FFFF);

        // reset in the middle of HALT
        step(); bus.ex_halt = 1'b1;
        step(); bus.ex_halt = 1'b0;
        at_neg();
        chk("mh_halted", 32'(bus.halted), 32'd1);
        step(); step();
        check_en = 1'b0; clr = 1'b0;
        #1;
        chk("mh_rst_halted", 32'(bus.halted), 32'd0);
        chk("mh_rst_state", 32'(bus.dbg_state), 32'(ST_RUN));
        chk("mh_rst_stall", bus.stall_count, 32'd0);
        chk("mh_rst_flush", bus.flush_count, 32'd0);
        step(); step();
        clr = 1'b1;
        step();
        check_en = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step();
            rand_inputs();
        end
        step(); idle();
        at_neg();
        check_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
